// File: rtl/phasecalc_cordic_if.sv
// Sample/result handshake bundle for the CORDIC phase calculator.
// The master supplies (x, y, tag) samples; the slave returns angle/magnitude results.
interface phasecalc_cordic_if #(
    parameter int INSIZE  = 13,
    parameter int OUTSIZE = 19,
    parameter int CHW     = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [INSIZE-1:0]  x;
    logic signed [INSIZE-1:0]  y;
    logic [CHW-1:0]            in_chan;
    logic                      out_valid;
    logic signed [OUTSIZE-1:0] angle;
    logic [INSIZE:0]           mag;
    logic [CHW-1:0]            out_chan;

    modport master (
        output in_valid, x, y, in_chan,
        input  in_ready, out_valid, angle, mag, out_chan
    );

    modport slave (
        input  in_valid, x, y, in_chan,
        output in_ready, out_valid, angle, mag, out_chan
    );
endinterface

// File: rtl/phasecalc_cordic.sv
// Iterative full-quadrant CORDIC vectoring unit: (x, y) -> angle in degrees*1024
// and gain-compensated magnitude, one micro-rotation per clock, valid/ready handshake.
module phasecalc_cordic #(
    parameter int INSIZE      = 13,
    parameter int OUTSIZE     = 19,
    parameter int ITER        = 16,
    parameter int ROMSIZE     = 16,
    parameter int COUNTERSIZE = 5,
    parameter int MAG_COMP    = 1,
    parameter int CHW         = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    phasecalc_cordic_if.slave  s_if
);
    // Fractional guard bits keep truncation in the shifts from steering the
    // late, tiny rotations the wrong way.
    localparam int GUARD = 10;
    localparam int DW    = INSIZE + 2 + GUARD;
    localparam int ZW    = OUTSIZE + 2;
    localparam int MW    = INSIZE + 1;
    localparam logic signed [ZW-1:0]      Z_PI   = ZW'(184320);
    localparam logic signed [OUTSIZE-1:0] ANG_PI = OUTSIZE'(184320);

    typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_t;

    state_t                    r_state, w_state_next;
    logic signed [DW-1:0]      r_xr, r_yr;
    logic signed [ZW-1:0]      r_z;
    logic [COUNTERSIZE-1:0]    r_iter;
    logic [CHW-1:0]            r_chan;
    logic                      r_zero, r_negaxis;
    logic signed [OUTSIZE-1:0] r_angle;
    logic [MW-1:0]             r_mag;
    logic [CHW-1:0]            r_out_chan;

    logic signed [DW-1:0] w_xe, w_ye, w_xr0, w_yr0;
    logic signed [ZW-1:0] w_z0;
    logic                 w_zero, w_negaxis;
    logic signed [DW-1:0] w_xs, w_ys, w_x_step, w_y_step;
    logic signed [ZW-1:0] w_atan, w_z_step;
    logic                 w_d, w_last;
    logic signed [DW-1:0] w_comp, w_mraw, w_mint;
    logic [MW-1:0]        w_mag;

    function automatic logic signed [ZW-1:0] atan_deg(input logic [COUNTERSIZE-1:0] idx);
        int v;
        case (int'(idx))
            0:       v = 46080;
            1:       v = 27203;
            2:       v = 14373;
            3:       v = 7296;
            4:       v = 3662;
            5:       v = 1833;
            6:       v = 917;
            7:       v = 458;
            8:       v = 229;
            9:       v = 115;
            10:      v = 57;
            11:      v = 29;
            12:      v = 14;
            13:      v = 7;
            14:      v = 4;
            15:      v = 2;
            16:      v = 1;
            default: v = 0;
        endcase
        if (int'(idx) >= ROMSIZE) v = 0;
        return ZW'(v);
    endfunction

    // Left half-plane samples are flipped by 180 degrees so the rotations converge.
    always_comb begin
        w_xe      = {{2{s_if.x[INSIZE-1]}}, s_if.x, {GUARD{1'b0}}};
        w_ye      = {{2{s_if.y[INSIZE-1]}}, s_if.y, {GUARD{1'b0}}};
        w_xr0     = w_xe;
        w_yr0     = w_ye;
        w_z0      = '0;
        w_zero    = (s_if.x == '0) && (s_if.y == '0);
        w_negaxis = s_if.x[INSIZE-1] && (s_if.y == '0);
        if (s_if.x[INSIZE-1]) begin
            w_xr0 = -w_xe;
            w_yr0 = -w_ye;
            w_z0  = s_if.y[INSIZE-1] ? -Z_PI : Z_PI;
        end
    end

    always_comb begin
        w_d      = ~r_yr[DW-1];
        w_xs     = r_xr >>> r_iter;
        w_ys     = r_yr >>> r_iter;
        w_atan   = atan_deg(r_iter);
        w_x_step = w_d ? (r_xr + w_ys)   : (r_xr - w_ys);
        w_y_step = w_d ? (r_yr - w_xs)   : (r_yr + w_xs);
        w_z_step = w_d ? (r_z  + w_atan) : (r_z  - w_atan);
        w_last   = (r_iter == COUNTERSIZE'(ITER - 1));
    end

    // 1/K ~= 0.60742; rounded back to integer and clamped to the unsigned output range.
    always_comb begin
        w_comp = (w_x_step >>> 1) + (w_x_step >>> 3) - (w_x_step >>> 6) - (w_x_step >>> 9);
        w_mraw = (MAG_COMP != 0) ? w_comp : w_x_step;
        w_mint = (w_mraw + DW'(1 << (GUARD - 1))) >>> GUARD;
        if (w_mint[DW-1])
            w_mag = '0;
        else if (|w_mint[DW-2:MW])
            w_mag = '1;
        else
            w_mag = w_mint[MW-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_xr       <= '0;
            r_yr       <= '0;
            r_z        <= '0;
            r_iter     <= '0;
            r_chan     <= '0;
            r_zero     <= 1'b0;
            r_negaxis  <= 1'b0;
            r_angle    <= '0;
            r_mag      <= '0;
            r_out_chan <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (s_if.in_valid) begin
                        r_xr      <= w_xr0;
                        r_yr      <= w_yr0;
                        r_z       <= w_z0;
                        r_iter    <= '0;
                        r_chan    <= s_if.in_chan;
                        r_zero    <= w_zero;
                        r_negaxis <= w_negaxis;
                    end
                end
                S_ROTATE: begin
                    r_xr   <= w_x_step;
                    r_yr   <= w_y_step;
                    r_z    <= w_z_step;
                    r_iter <= r_iter + 1'b1;
                    if (w_last) begin
                        r_angle    <= r_zero ? '0 : (r_negaxis ? ANG_PI : w_z_step[OUTSIZE-1:0]);
                        r_mag      <= r_zero ? '0 : w_mag;
                        r_out_chan <= r_chan;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next   = r_state;
        s_if.in_ready  = 1'b0;
        s_if.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_if.in_ready = 1'b1;
                if (s_if.in_valid) w_state_next = S_ROTATE;
            end
            S_ROTATE: if (w_last) w_state_next = S_DONE;
            S_DONE: begin
                s_if.out_valid = 1'b1;
                w_state_next   = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign s_if.angle    = r_angle;
    assign s_if.mag      = r_mag;
    assign s_if.out_chan = r_out_chan;
endmodule

// File: tb/tb_phasecalc_cordic.sv
// Directed bench for phasecalc_cordic: vector table, back-to-back handshake,
// mid-rotation reset and a reduced-iteration uncompensated instance.
module tb_phasecalc_cordic;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    phasecalc_cordic_if #(.INSIZE(13), .OUTSIZE(19), .CHW(2)) ifa ();
    phasecalc_cordic_if #(.INSIZE(16), .OUTSIZE(19), .CHW(2)) ifb ();

    phasecalc_cordic #(.INSIZE(13), .OUTSIZE(19), .ITER(16), .ROMSIZE(16),
                       .COUNTERSIZE(5), .MAG_COMP(1), .CHW(2))
        dut (.i_clk(clk), .i_rst_n(rst_n), .s_if(ifa));

    phasecalc_cordic #(.INSIZE(16), .OUTSIZE(19), .ITER(8), .ROMSIZE(16),
                       .COUNTERSIZE(5), .MAG_COMP(0), .CHW(2))
        dut8 (.i_clk(clk), .i_rst_n(rst_n), .s_if(ifb));

    typedef struct {
        logic signed [12:0] x;
        logic signed [12:0] y;
        logic [1:0]         ch;
        int                 a;
        int                 at;
        int                 m;
        int                 mt;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        longint diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        n_vec++;
        if (diff > tol) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic send_a(input logic signed [12:0] xv, input logic signed [12:0] yv,
                          input logic [1:0] ch,
                          output int ang, output int mg, output int och, output int lat);
        int  k;
        bit  got;
        got = 0;
        lat = -1; ang = 0; mg = -1; och = -1;
        @(negedge clk);
        for (int t = 0; t < 40 && !ifa.in_ready; t++) @(negedge clk);
        ifa.x = xv; ifa.y = yv; ifa.in_chan = ch; ifa.in_valid = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (ifa.out_valid) begin
                got = 1;
                lat = cyc - k;
                ang = ifa.angle;
                mg  = ifa.mag;
                och = ifa.out_chan;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[11];
        int   ang, mg, och, lat;
        int   bx[4], by[4], ba[4], btol[4];
        int   acc[4], ov[4], bang[4], bch[4];
        int   pulses;

        vt[0]  = '{13'sd1000,   13'sd0,     2'd0, 0,       4, 1000, 3};
        vt[1]  = '{13'sd0,      13'sd1000,  2'd1, 92160,   4, 1000, 3};
        vt[2]  = '{13'sd0,     -13'sd1000,  2'd2, -92160,  4, 1000, 3};
        vt[3]  = '{-13'sd1000,  13'sd0,     2'd3, 184320,  0, 1000, 3};
        vt[4]  = '{-13'sd1000, -13'sd1,     2'd0, -184261, 4, 1000, 3};
        vt[5]  = '{-13'sd1000,  13'sd1,     2'd1, 184261,  4, 1000, 3};
        vt[6]  = '{-13'sd4096, -13'sd4096,  2'd2, -138240, 4, 5793, 12};
        vt[7]  = '{13'sd0,      13'sd0,     2'd3, 0,       0, 0,    0};
        vt[8]  = '{13'sd4095,  -13'sd4096,  2'd0, -46087,  4, 5792, 12};
        vt[9]  = '{13'sd3000,   13'sd4000,  2'd1, 54405,   4, 5000, 12};
        vt[10] = '{-13'sd3000,  13'sd4000,  2'd2, 129915,  4, 5000, 12};

        ifa.in_valid = 1'b0; ifa.x = '0; ifa.y = '0; ifa.in_chan = '0;
        ifb.in_valid = 1'b0; ifb.x = '0; ifb.y = '0; ifb.in_chan = '0;

        #12;
        check("rst_in_ready",  ifa.in_ready,  1, 0);
        check("rst_out_valid", ifa.out_valid, 0, 0);
        check("rst_angle",     ifa.angle,     0, 0);
        check("rst_mag",       ifa.mag,       0, 0);
        check("rst_out_chan",  ifa.out_chan,  0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            send_a(vt[i].x, vt[i].y, vt[i].ch, ang, mg, och, lat);
            $display("vec %0d: x=%0d y=%0d ch=%0d -> angle=%0d mag=%0d chan=%0d lat=%0d",
                     i, vt[i].x, vt[i].y, vt[i].ch, ang, mg, och, lat);
            check($sformatf("v%0d_angle", i), ang, vt[i].a, vt[i].at);
            check($sformatf("v%0d_mag", i),   mg,  vt[i].m, vt[i].mt);
            check($sformatf("v%0d_chan", i),  och, vt[i].ch, 0);
            check($sformatf("v%0d_lat", i),   lat, 17, 0);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), ifa.out_valid, 0, 0);
        end

        repeat (6) @(negedge clk);
        check("hold_angle", ifa.angle, 129915, 4);
        check("hold_chan",  ifa.out_chan, 2, 0);

        // Continuous in_valid; garbage presented while busy must be ignored.
        bx = '{1000, 0, -1000, 3000};
        by = '{0, 1000, 0, 4000};
        ba = '{0, 92160, 184320, 54405};
        btol = '{4, 4, 0, 4};
        for (int j = 0; j < 4; j++) begin
            acc[j] = -1000; ov[j] = -1; bang[j] = 0; bch[j] = -1;
        end
        fork
            begin
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    ifa.x = 13'(bx[j]); ifa.y = 13'(by[j]); ifa.in_chan = 2'(j);
                    ifa.in_valid = 1'b1;
                    for (int t = 0; t < 40 && !ifa.in_ready; t++) @(negedge clk);
                    acc[j] = cyc;
                    @(posedge clk); #1;
                    ifa.x = -13'sd7; ifa.y = 13'sd1234; ifa.in_chan = ~2'(j);
                    repeat (4) @(negedge clk);
                end
                ifa.in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    bit got;
                    got = 0;
                    for (int t = 0; t < 60 && !got; t++) begin
                        @(negedge clk);
                        if (ifa.out_valid) begin
                            got = 1;
                            ov[j] = cyc; bang[j] = ifa.angle; bch[j] = ifa.out_chan;
                        end
                    end
                end
            end
        join
        for (int j = 0; j < 4; j++) begin
            $display("b2b %0d: accept@%0d result@%0d angle=%0d chan=%0d",
                     j, acc[j], ov[j], bang[j], bch[j]);
            check($sformatf("b2b%0d_lat", j),   ov[j] - acc[j], 17, 0);
            check($sformatf("b2b%0d_chan", j),  bch[j], j, 0);
            check($sformatf("b2b%0d_angle", j), bang[j], ba[j], btol[j]);
            if (j > 0) check($sformatf("b2b%0d_spacing", j), acc[j] - acc[j-1], 18, 0);
        end

        // Reset in the middle of a rotation discards the sample.
        @(negedge clk);
        ifa.x = 13'sd1000; ifa.y = 13'sd500; ifa.in_chan = 2'd1; ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_angle",     ifa.angle,     0, 0);
        check("mid_rst_mag",       ifa.mag,       0, 0);
        check("mid_rst_chan",      ifa.out_chan,  0, 0);
        check("mid_rst_out_valid", ifa.out_valid, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", ifa.in_ready, 1, 0);
        pulses = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (ifa.out_valid) pulses++;
        end
        check("post_rst_no_pulse", pulses, 0, 0);

        // ITER=8, uncompensated, INSIZE=16. The 8-step residual is bounded by
        // atan(2^-7)*1024 ~= 458, raw gain K8 ~= 1.64674 -> 46578.
        begin
            int  k, lat8, ang8, mag8;
            bit  got;
            got = 0; lat8 = -1; ang8 = 0; mag8 = -1;
            @(negedge clk);
            for (int t = 0; t < 40 && !ifb.in_ready; t++) @(negedge clk);
            ifb.x = 16'sd20000; ifb.y = 16'sd20000; ifb.in_chan = 2'd3; ifb.in_valid = 1'b1;
            k = cyc;
            @(posedge clk); #1;
            ifb.in_valid = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (ifb.out_valid) begin
                    got = 1; lat8 = cyc - k; ang8 = ifb.angle; mag8 = ifb.mag;
                end
            end
            $display("iter8: x=20000 y=20000 -> angle=%0d mag=%0d lat=%0d", ang8, mag8, lat8);
            check("iter8_lat",   lat8, 9, 0);
            check("iter8_angle", ang8, 46080, 460);
            check("iter8_mag",   mag8, 46580, 233);
            check("iter8_chan",  ifb.out_chan, 3, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
